// File: rtl/bsd_tap_ctrl_pkg.sv
// Shared types for the boundary-scan TAP controller: state encoding, opcodes,
// IR capture pattern and the 1149.1 next-state function.
package bsd_tap_ctrl_pkg;

    // Standard 1149.1 state encoding, so tap_state reads like any TAP debugger trace.
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_t;

    localparam int          OP_IDCODE      = 1;
    localparam logic [1:0]  IR_CAPTURE_LSB = 2'b01;

    function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
        tap_state_t n;
        n = TEST_LOGIC_RESET;
        case (s)
            TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = tms ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = tms ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bsd_tap_ctrl_if.sv
// Serial scan pins plus the strobes/selects shared with the attached UTDRs.
interface bsd_tap_ctrl_if #(
    parameter int NUM_UTDR = 4
);
    logic                tms;
    logic                tdi;
    logic                tdo;
    logic                tdo_en;
    logic                bsd_capture_en;
    logic                bsd_shift_en;
    logic                bsd_update_en;
    logic [NUM_UTDR-1:0] utdr_tdo;
    logic [NUM_UTDR-1:0] inst_enable;

    modport master (
        output tms, tdi, utdr_tdo,
        input  tdo, tdo_en, bsd_capture_en, bsd_shift_en, bsd_update_en, inst_enable
    );

    modport slave (
        input  tms, tdi, utdr_tdo,
        output tdo, tdo_en, bsd_capture_en, bsd_shift_en, bsd_update_en, inst_enable
    );
endinterface

// File: rtl/bsd_tap_ctrl_fsm.sv
// 16-state TAP FSM with one-hot style decode strobes for the IR/DR datapaths.
module bsd_tap_ctrl_fsm
    import bsd_tap_ctrl_pkg::*;
(
    input  logic       capture_clk,
    input  logic       bsd_reset,
    input  logic       tms,
    output tap_state_t state,
    output logic       is_tlr,
    output logic       going_tlr,
    output logic       is_capture_dr,
    output logic       is_shift_dr,
    output logic       is_update_dr,
    output logic       is_capture_ir,
    output logic       is_shift_ir,
    output logic       is_update_ir
);

    tap_state_t state_nxt;

    always_ff @(posedge capture_clk or negedge bsd_reset) begin
        if (!bsd_reset) state <= TEST_LOGIC_RESET;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = next_state(state, tms);
    end

    always_comb begin
        is_tlr        = (state == TEST_LOGIC_RESET);
        going_tlr     = (state_nxt == TEST_LOGIC_RESET);
        is_capture_dr = (state == CAPTURE_DR);
        is_shift_dr   = (state == SHIFT_DR);
        is_update_dr  = (state == UPDATE_DR);
        is_capture_ir = (state == CAPTURE_IR);
        is_shift_ir   = (state == SHIFT_IR);
        is_update_ir  = (state == UPDATE_IR);
    end

endmodule

// File: rtl/bsd_tap_ctrl.sv
// TAP controller top: IR, BYPASS and IDCODE registers, instruction decode,
// UTDR strobes and the tdo mux.
module bsd_tap_ctrl
    import bsd_tap_ctrl_pkg::*;
#(
    parameter int                  IR_WIDTH   = 4,
    parameter int                  NUM_UTDR   = 4,
    parameter logic [IR_WIDTH-1:0] UTDR_BASE  = 4'h8,
    parameter logic [31:0]         IDCODE_VAL = 32'h0000_0001
) (
    input  logic                capture_clk,
    input  logic                bsd_reset,
    bsd_tap_ctrl_if.slave       tap,
    output logic [IR_WIDTH-1:0] ir_value,
    output logic [3:0]          tap_state
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(OP_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(IR_CAPTURE_LSB);

    tap_state_t          state;
    logic                is_tlr, going_tlr;
    logic                is_capture_dr, is_shift_dr, is_update_dr;
    logic                is_capture_ir, is_shift_ir, is_update_ir;

    logic [IR_WIDTH-1:0] ir, ir_shift;
    logic                bypass;
    logic [31:0]         idcode_sr;
    logic [NUM_UTDR-1:0] inst_en;
    logic                utdr_sel, idcode_sel;

    bsd_tap_ctrl_fsm u_fsm (
        .capture_clk   (capture_clk),
        .bsd_reset     (bsd_reset),
        .tms           (tap.tms),
        .state         (state),
        .is_tlr        (is_tlr),
        .going_tlr     (going_tlr),
        .is_capture_dr (is_capture_dr),
        .is_shift_dr   (is_shift_dr),
        .is_update_dr  (is_update_dr),
        .is_capture_ir (is_capture_ir),
        .is_shift_ir   (is_shift_ir),
        .is_update_ir  (is_update_ir)
    );

    // IR is also forced on the edge entering TLR, so it reads IDCODE for every cycle spent in TLR.
    always_ff @(posedge capture_clk or negedge bsd_reset) begin
        if (!bsd_reset) begin
            ir        <= IR_IDCODE;
            ir_shift  <= '0;
            bypass    <= 1'b0;
            idcode_sr <= IDCODE_VAL;
        end else begin
            if (is_tlr || going_tlr) ir <= IR_IDCODE;
            else if (is_update_ir)   ir <= ir_shift;

            if (is_capture_ir)    ir_shift <= IR_CAPTURE;
            else if (is_shift_ir) ir_shift <= {tap.tdi, ir_shift[IR_WIDTH-1:1]};

            if (is_capture_dr) begin
                bypass    <= 1'b0;
                idcode_sr <= IDCODE_VAL;
            end else if (is_shift_dr) begin
                bypass    <= tap.tdi;
                idcode_sr <= {tap.tdi, idcode_sr[31:1]};
            end
        end
    end

    // Unlisted opcodes (including all-ones) fall through to BYPASS.
    always_comb begin
        inst_en = '0;
        for (int k = 0; k < NUM_UTDR; k++)
            inst_en[k] = (ir == IR_WIDTH'(int'(UTDR_BASE) + k));
        utdr_sel   = |inst_en;
        idcode_sel = (ir == IR_IDCODE);
    end

    always_comb begin
        tap.inst_enable    = inst_en;
        tap.bsd_capture_en = utdr_sel & (is_capture_dr | is_shift_dr);
        tap.bsd_shift_en   = utdr_sel & is_shift_dr;
        tap.bsd_update_en  = utdr_sel & is_update_dr;
        tap.tdo_en         = is_shift_dr | is_shift_ir;

        tap.tdo = 1'b0;
        if (is_shift_ir)
            tap.tdo = ir_shift[0];
        else if (is_shift_dr) begin
            if (utdr_sel)        tap.tdo = |(inst_en & tap.utdr_tdo);
            else if (idcode_sel) tap.tdo = idcode_sr[0];
            else                 tap.tdo = bypass;
        end
    end

    assign ir_value  = ir;
    assign tap_state = state;

endmodule

// File: tb/tb_bsd_tap_ctrl.sv
// Bench for bsd_tap_ctrl: table-driven TAP model checked every cycle, plus
// directed scans with hand-computed expectations.
module tb_bsd_tap_ctrl;

    localparam int          NU  = 4;
    localparam logic [3:0]  UB  = 4'h8;
    localparam logic [31:0] IDC = 32'h4BA0_0477;

    logic       capture_clk = 1'b0;
    logic       bsd_reset;
    logic [3:0] ir_value;
    logic [3:0] tap_state;

    bsd_tap_ctrl_if #(.NUM_UTDR(NU)) tap ();

    bsd_tap_ctrl #(
        .IR_WIDTH   (4),
        .NUM_UTDR   (NU),
        .UTDR_BASE  (UB),
        .IDCODE_VAL (IDC)
    ) dut (
        .capture_clk (capture_clk),
        .bsd_reset   (bsd_reset),
        .tap         (tap),
        .ir_value    (ir_value),
        .tap_state   (tap_state)
    );

    always #5 capture_clk = ~capture_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transition table indexed by 1149.1 state code: [0]=TMS low, [1]=TMS high.
    logic [3:0] n0 [16] = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6,
                            4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    logic [3:0] n1 [16] = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4,
                            4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};

    logic [3:0]  m_st  = 4'hF;
    logic [3:0]  m_ir  = 4'h1;
    logic [3:0]  m_irs = 4'h0;
    logic        m_byp = 1'b0;
    logic [31:0] m_idc = IDC;

    always @(posedge capture_clk or negedge bsd_reset) begin
        if (!bsd_reset) begin
            m_st <= 4'hF; m_ir <= 4'h1; m_irs <= 4'h0; m_byp <= 1'b0; m_idc <= IDC;
        end else begin
            logic [3:0] nx;
            nx = tap.tms ? n1[m_st] : n0[m_st];
            if (m_st == 4'hF || nx == 4'hF) m_ir <= 4'h1;
            else if (m_st == 4'hD)          m_ir <= m_irs;
            if (m_st == 4'hE)      m_irs <= 4'b0001;
            else if (m_st == 4'hA) m_irs <= {tap.tdi, m_irs[3:1]};
            if (m_st == 4'h6) begin
                m_byp <= 1'b0; m_idc <= IDC;
            end else if (m_st == 4'h2) begin
                m_byp <= tap.tdi; m_idc <= {tap.tdi, m_idc[31:1]};
            end
            m_st <= nx;
        end
    end

    function automatic logic [3:0] exp_ie(input logic [3:0] ir);
        int d;
        d = int'(ir) - int'(UB);
        if (d >= 0 && d < NU) return 4'(1 << d);
        return 4'h0;
    endfunction

    always @(negedge capture_clk) begin
        if (chk_en) begin
            logic [3:0] ie;
            logic       usel, shdr, e_tdo;
            ie   = exp_ie(m_ir);
            usel = (ie != 4'h0);
            shdr = (m_st == 4'h2);
            e_tdo = 1'b0;
            if (m_st == 4'hA)     e_tdo = m_irs[0];
            else if (shdr) begin
                if (usel)              e_tdo = |(ie & tap.utdr_tdo);
                else if (m_ir == 4'h1) e_tdo = m_idc[0];
                else                   e_tdo = m_byp;
            end
            check("cyc_state",   32'(tap_state),          32'(m_st));
            check("cyc_ir",      32'(ir_value),           32'(m_ir));
            check("cyc_inst_en", 32'(tap.inst_enable),    32'(ie));
            check("cyc_tdo_en",  32'(tap.tdo_en),         32'(shdr || m_st == 4'hA));
            check("cyc_cap_en",  32'(tap.bsd_capture_en), 32'(usel && (shdr || m_st == 4'h6)));
            check("cyc_sh_en",   32'(tap.bsd_shift_en),   32'(usel && shdr));
            check("cyc_upd_en",  32'(tap.bsd_update_en),  32'(usel && m_st == 4'h5));
            check("cyc_tdo",     32'(tap.tdo),            32'(e_tdo));
        end
    end

    task automatic tick(input logic t_ms, input logic t_di);
        tap.tms      = t_ms;
        tap.tdi      = t_di;
        tap.utdr_tdo = NU'($urandom);
        @(posedge capture_clk);
        #1;
    endtask

    // From RUN_TEST_IDLE, scan n bits (LSB first) through IR or DR, back to RUN_TEST_IDLE.
    task automatic scan(input bit is_ir, input int n, input logic [31:0] din, output logic [31:0] dout);
        dout = '0;
        tick(1'b1, 1'b0);
        if (is_ir) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tap.tdo;
            tick(i == n - 1, din[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] d;
        int          steps;
        bsd_reset    = 1'b0;
        tap.tms      = 1'b1;
        tap.tdi      = 1'b0;
        tap.utdr_tdo = '0;
        #12;
        check("rst_state",  32'(tap_state),       32'hF);
        check("rst_ir",     32'(ir_value),        32'h1);
        check("rst_tdo",    32'(tap.tdo),         32'h0);
        check("rst_inst",   32'(tap.inst_enable), 32'h0);
        chk_en = 1'b1;
        @(posedge capture_clk); #1;
        bsd_reset = 1'b1;

        // 5x TMS=1 from every state returns to TLR
        for (int t = 0; t < 16; t++) begin
            steps = 0;
            while (m_st != 4'(t) && steps < 400) begin
                tick(1'($urandom), 1'($urandom));
                steps++;
            end
            check("walk_reach", 32'(m_st), 32'(t));
            for (int k = 0; k < 5; k++) tick(1'b1, 1'($urandom));
            check("five_ones_state", 32'(tap_state),       32'hF);
            check("five_ones_ir",    32'(ir_value),        32'h1);
            check("five_ones_en",    32'({tap.bsd_capture_en, tap.bsd_shift_en, tap.bsd_update_en, tap.inst_enable}), 32'h0);
        end

        // default IDCODE readout
        tick(1'b0, 1'b0);
        scan(1'b0, 32, 32'h0, d);
        check("idcode_out", d, IDC);

        // all-ones BYPASS: one-bit delay with a leading zero
        scan(1'b1, 4, 32'hF, d);
        check("ir_f_capture", d[3:0], 4'b0001);
        check("ir_f_value", 32'(ir_value), 32'hF);
        scan(1'b0, 8, 32'hA5, d);
        check("bypass_a5", d[7:0], 8'h4A);

        // unassigned opcode 7 also bypasses
        scan(1'b1, 4, 32'h7, d);
        check("ir_7_capture", d[3:0], 4'b0001);
        check("ir_7_inst", 32'(tap.inst_enable), 32'h0);
        scan(1'b0, 3, 32'b011, d);
        check("bypass_op7", d[2:0], 3'b110);

        // UTDR[2]
        scan(1'b1, 4, 32'(UB + 4'd2), d);
        check("utdr_inst", 32'(tap.inst_enable), 32'b0100);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("utdr_cap_dr", 32'({tap.bsd_capture_en, tap.bsd_shift_en}), 32'b10);
        tick(1'b0, 1'b0);
        check("utdr_sh_dr", 32'({tap.bsd_capture_en, tap.bsd_shift_en}), 32'b11);
        tap.utdr_tdo = 4'b0100; #1;
        check("utdr_tdo_hi", 32'(tap.tdo), 32'h1);
        tap.utdr_tdo = 4'b1011; #1;
        check("utdr_tdo_lo", 32'(tap.tdo), 32'h0);
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check("utdr_upd", 32'(tap.bsd_update_en), 32'h1);
        tick(1'b0, 1'b0);
        check("utdr_upd_pulse", 32'(tap.bsd_update_en), 32'h0);

        // reset in the middle of a UTDR shift
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("pre_rst_shift", 32'(tap.bsd_shift_en), 32'h1);
        #2 bsd_reset = 1'b0;
        #1;
        check("midrst_state", 32'(tap_state),       32'hF);
        check("midrst_inst",  32'(tap.inst_enable), 32'h0);
        check("midrst_ir",    32'(ir_value),        32'h1);
        check("midrst_tdo",   32'(tap.tdo),         32'h0);
        tap.tms = 1'b1;
        @(posedge capture_clk); #1;
        bsd_reset = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("post_rst_state", 32'(tap_state), 32'hC);
        scan(1'b0, 32, 32'h0, d);
        check("post_rst_idcode", d, IDC);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
